seq_and_reduce: RTL and testbench

Multi-cycle bitwise AND reduction engine. Operands arrive one per accepted handshake rather than as parallel inputs, and the block delivers a registered result with a completion pulse. It sits between an operand producer (switch/FIFO front end) and the display/result logic in the Ch 4–7 lab designs. It is the sequential FSMD counterpart of the combinational multi-input AND used in those labs.

---
 rtl/seq_and_reduce_pkg.sv | 19 +
 rtl/seq_and_reduce_op_counter.sv | 27 ++
 rtl/seq_and_reduce.sv | 84 ++++++++
 tb/tb_seq_and_reduce.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_and_reduce_pkg.sv
// Shared state encoding and width helper for the sequential AND reduction engine.
package seq_and_reduce_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b01;
    localparam logic [1:0] ST_ACCUM = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // Ceiling log2; sizes the operand counter so it can hold the value N.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_and_reduce_op_counter.sv
// Operand counter: clears on clr, counts accepted operands, saturates at N.
// tc flags that the next increment reaches N, i.e. the current operand is the last.
module op_counter #(
    parameter int N  = 3,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] q,
    output logic          tc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != CW'(N))) begin
            q <= q + 1'b1;
        end
    end

    assign tc = (q == CW'(N - 1));

endmodule

// File: rtl/seq_and_reduce.sv
// Multi-cycle bitwise AND of N operands taken one per din handshake.
// Result y/used and done_tick are registered and appear in the DONE cycle.
module seq_and_reduce
    import seq_and_reduce_pkg::*;
#(
    parameter int W          = 8,
    parameter int N          = 3,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [W-1:0]             din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     ready,
    output logic                     done_tick,
    output logic [W-1:0]             y,
    output logic [clog2(N+1)-1:0]    used
);

    localparam int CW = clog2(N + 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_tc;
    logic          accept;
    logic          last;

    // Handshake readiness is decoded from state only, never from din_valid/start.
    assign ready     = (state == ST_IDLE);
    assign din_ready = (state == ST_LOAD) || (state == ST_ACCUM);
    assign accept    = din_valid && din_ready;

    assign acc_nxt = (state == ST_LOAD) ? din : (acc & din);
    assign last    = cnt_tc || (EARLY_EXIT && (acc_nxt == '0));

    op_counter #(
        .N  (N),
        .CW (CW)
    ) u_op_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (ready && start),
        .en      (accept),
        .q       (cnt),
        .tc      (cnt_tc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD,
            ST_ACCUM: if (accept) state_nxt = last ? ST_DONE : ST_ACCUM;
            ST_DONE:  state_nxt = ST_IDLE;
        endcase
    end

    // Results are captured on the final accept so they are valid throughout DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            acc       <= '1;
            y         <= '0;
            used      <= '0;
            done_tick <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_tick <= accept && last;
            if (accept) begin
                acc <= acc_nxt;
            end
            if (accept && last) begin
                y    <= acc_nxt;
                used <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_and_reduce.sv
// Directed bench: three instances (N=3, N=3 early exit, N=1) share one stimulus stream.
module tb_seq_and_reduce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       din_valid;
    logic [7:0] din;

    logic       a_din_ready, a_ready, a_done;
    logic [7:0] a_y;
    logic [1:0] a_used;
    logic       b_din_ready, b_ready, b_done;
    logic [7:0] b_y;
    logic [1:0] b_used;
    logic       c_din_ready, c_ready, c_done;
    logic [7:0] c_y;
    logic [0:0] c_used;

    int checks = 0;
    int errors = 0;
    int nd_a   = 0;
    int nd_c   = 0;
    int snap_a;
    int snap_c;

    always #5 clk = ~clk;

    seq_and_reduce #(.W(8), .N(3), .EARLY_EXIT(1'b0)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(a_din_ready), .ready(a_ready), .done_tick(a_done), .y(a_y), .used(a_used)
    );

    seq_and_reduce #(.W(8), .N(3), .EARLY_EXIT(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(b_din_ready), .ready(b_ready), .done_tick(b_done), .y(b_y), .used(b_used)
    );

    seq_and_reduce #(.W(8), .N(1), .EARLY_EXIT(1'b0)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(c_din_ready), .ready(c_ready), .done_tick(c_done), .y(c_y), .used(c_used)
    );

    always @(posedge clk) begin
        if (a_done) nd_a++;
        if (c_done) nd_c++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set here are sampled at the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        step();
        step();
        chk("rst_y",         a_y, 8'h00);
        chk("rst_used",      a_used, 2'd0);
        chk("rst_done",      a_done, 1'b0);
        chk("rst_ready",     a_ready, 1'b1);
        chk("rst_din_ready", a_din_ready, 1'b0);
        reset_n = 1'b1;

        // Back-to-back operands
        start = 1'b1;
        step();
        chk("t1_din_ready", a_din_ready, 1'b1);
        chk("t1_busy",      a_ready, 1'b0);
        start = 1'b0; din = 8'hF0; din_valid = 1'b1;
        step();
        din = 8'h3C;
        step();
        chk("t1_no_early", a_done, 1'b0);
        din = 8'hFF;
        step();
        din_valid = 1'b0;
        chk("t1_done",   a_done, 1'b1);
        chk("t1_y",      a_y, 8'h30);
        chk("t1_used",   a_used, 2'd3);
        chk("t1_ee_y",   b_y, 8'h30);
        chk("t1_n1_y",   c_y, 8'hF0);
        chk("t1_n1_use", c_used, 1'b1);
        step();
        chk("t1_tick_end", a_done, 1'b0);
        chk("t1_ready",    a_ready, 1'b1);
        chk("t1_y_hold",   a_y, 8'h30);

        // Stalled producer; din is zeroed while invalid to expose any stray accept
        start = 1'b1;
        step();
        start = 1'b0; din = 8'hF0; din_valid = 1'b1;
        step();
        din_valid = 1'b0; din = 8'h00;
        step();
        step();
        chk("t2_stall_c4", a_done, 1'b0);
        din = 8'h3C; din_valid = 1'b1;
        step();
        din_valid = 1'b0; din = 8'h00;
        step();
        step();
        din = 8'hFF; din_valid = 1'b1;
        chk("t2_stall_c7", a_done, 1'b0);
        step();
        din_valid = 1'b0;
        chk("t2_done", a_done, 1'b1);
        chk("t2_y",    a_y, 8'h30);
        chk("t2_used", a_used, 2'd3);
        chk("t2_ee_y", b_y, 8'h30);
        step();

        // Reset in the middle of a reduction
        start = 1'b1;
        step();
        start = 1'b0; din = 8'hAA; din_valid = 1'b1;
        step();
        din = 8'hFF;
        step();
        snap_a    = nd_a;
        din_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("t4_y",         a_y, 8'h00);
        chk("t4_used",      a_used, 2'd0);
        chk("t4_ready",     a_ready, 1'b1);
        chk("t4_done",      a_done, 1'b0);
        chk("t4_din_ready", a_din_ready, 1'b0);
        step();
        reset_n = 1'b1;
        start   = 1'b1;
        chk("t4_no_tick", nd_a - snap_a, 0);
        step();
        start = 1'b0; din = 8'hAA; din_valid = 1'b1;
        step();
        din = 8'hFF;
        step();
        din = 8'hAA;
        step();
        din_valid = 1'b0;
        chk("t4_new_done", a_done, 1'b1);
        chk("t4_new_y",    a_y, 8'hAA);
        chk("t4_new_used", a_used, 2'd3);
        step();

        // Early exit versus full reduction
        start = 1'b1;
        step();
        start = 1'b0; din = 8'h0F; din_valid = 1'b1;
        step();
        din = 8'hF0;
        step();
        chk("t3_ee_done",      b_done, 1'b1);
        chk("t3_ee_y",         b_y, 8'h00);
        chk("t3_ee_used",      b_used, 2'd2);
        chk("t3_ee_no_accept", b_din_ready, 1'b0);
        din = 8'hFF;
        step();
        din_valid = 1'b0;
        chk("t3_full_done", a_done, 1'b1);
        chk("t3_full_y",    a_y, 8'h00);
        chk("t3_full_used", a_used, 2'd3);
        chk("t3_ee_tick1",  b_done, 1'b0);
        chk("t3_ee_ready",  b_ready, 1'b1);
        step();

        // N=1 and start while busy
        snap_a = nd_a;
        snap_c = nd_c;
        start = 1'b1;
        step();
        start = 1'b0; din = 8'h5A; din_valid = 1'b1;
        step();
        chk("t5_n1_done", c_done, 1'b1);
        chk("t5_n1_y",    c_y, 8'h5A);
        chk("t5_n1_used", c_used, 1'b1);
        start = 1'b1; din = 8'hFF;
        step();
        start = 1'b0; din = 8'h5A;
        step();
        chk("t5_a_done", a_done, 1'b1);
        chk("t5_a_y",    a_y, 8'h5A);
        step();
        step();
        step();
        din_valid = 1'b0;
        chk("t5_no_queue",  a_ready, 1'b1);
        chk("t5_a_ticks",   nd_a - snap_a, 1);
        chk("t5_n1_ticks",  nd_c - snap_c, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
